// File: rtl/mac_feeder.sv
// Purpose : sequences one accumulation pass (25 / 150 / fc_len products) for a 6-lane MAC array:
//           issues activation/weight reads and forwards the returned operands to the lanes.
// Latency : start sampled at edge 0 -> reads cycles 1..N, mac_en cycles 2..N+1, result_valid N+2.
// Backpr. : stall freezes FETCH (no read, k and addresses hold); each stalled cycle delays the rest by one.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, MAC_layer    pass request and layer select (00 conv1, 01 conv2, 10 FC, 11 invalid)
//   fc_len, act_base    FC product count, activation window base address
//   stall               memory arbiter pause request
//   act_addr, wt_addr   read addresses, rd_en read strobe (data returns next cycle)
//   act_data, wt_data   returned activation / six lane weights
//   mac_a, mac_b        operands to the lanes, mac_en accumulate, mac_clr load-instead-of-add
//   layer_out           layer latched at accepted start, for the bias/ReLU stage
//   result_valid        one-cycle pulse when sums are final
//   busy, err           pass in progress, one-cycle pulse on rejected start
module mac_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  MAC_layer,
    input  logic [9:0]  fc_len,
    input  logic [9:0]  act_base,
    input  logic        stall,
    output logic [9:0]  act_addr,
    output logic [9:0]  wt_addr,
    output logic        rd_en,
    input  logic [15:0] act_data,
    input  logic [95:0] wt_data,
    output logic [15:0] mac_a,
    output logic [95:0] mac_b,
    output logic        mac_clr,
    output logic        mac_en,
    output logic [1:0]  layer_out,
    output logic        result_valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [9:0]  r_k;
    logic [9:0]  r_n;
    logic [9:0]  r_base;
    logic [1:0]  r_layer;
    logic        r_mac_en;
    logic        r_mac_clr;
    logic        r_err;

    logic        w_rd_en;
    logic        w_start_ok;
    logic        w_accept;
    logic        w_last;
    logic [9:0]  w_n_sel;

    // A start is only legal for the two conv layers or for a non-empty FC pass.
    always_comb begin
        w_start_ok = 1'b0;
        w_n_sel    = 10'd0;
        case (MAC_layer)
            2'b00: begin w_start_ok = 1'b1;             w_n_sel = 10'd25;  end
            2'b01: begin w_start_ok = 1'b1;             w_n_sel = 10'd150; end
            2'b10: begin w_start_ok = (fc_len != 10'd0); w_n_sel = fc_len;  end
            default: begin w_start_ok = 1'b0;           w_n_sel = 10'd0;   end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && start && w_start_ok;
    assign w_last   = (r_k == (r_n - 10'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!stall) begin
                    w_rd_en = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k       <= 10'd0;
            r_n       <= 10'd0;
            r_base    <= 10'd0;
            r_layer   <= 2'b00;
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Operands arrive one cycle after the read, so the MAC strobes are the read strobe delayed.
            r_mac_en  <= w_rd_en;
            r_mac_clr <= w_rd_en && (r_k == 10'd0);
            r_err     <= (r_state == S_IDLE) && start && !w_start_ok;
            if (w_accept) begin
                r_n     <= w_n_sel;
                r_base  <= act_base;
                r_layer <= MAC_layer;
                r_k     <= 10'd0;
            end else if (w_rd_en) begin
                r_k     <= r_k + 10'd1;
            end
        end
    end

    // Addresses are held (not strobed) while stalled; outside FETCH they read as zero.
    assign act_addr     = (r_state == S_FETCH) ? (r_base + r_k) : 10'd0;
    assign wt_addr      = (r_state == S_FETCH) ? r_k : 10'd0;
    assign rd_en        = w_rd_en;
    assign mac_en       = r_mac_en;
    assign mac_clr      = r_mac_clr;
    assign mac_a        = r_mac_en ? act_data : 16'd0;
    assign mac_b        = r_mac_en ? wt_data : 96'd0;
    assign layer_out    = r_layer;
    assign result_valid = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign err          = r_err;

endmodule

// File: tb/tb_mac_feeder.sv
// Purpose : randomized self-checking bench for mac_feeder against a per-cycle pass model.
// Latency : the model places reads, MAC strobes and result_valid from the product count and stall pattern.
// Backpr. : the bench drives random stall in every state; only FETCH cycles are expected to react.
module tb_mac_feeder;

    localparam int MAXC = 800;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [1:0]  MAC_layer;
    logic [9:0]  fc_len;
    logic [9:0]  act_base;
    logic        stall;
    logic [9:0]  act_addr;
    logic [9:0]  wt_addr;
    logic        rd_en;
    logic [15:0] act_data;
    logic [95:0] wt_data;
    logic [15:0] mac_a;
    logic [95:0] mac_b;
    logic        mac_clr;
    logic        mac_en;
    logic [1:0]  layer_out;
    logic        result_valid;
    logic        busy;
    logic        err;

    mac_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .MAC_layer    (MAC_layer),
        .fc_len       (fc_len),
        .act_base     (act_base),
        .stall        (stall),
        .act_addr     (act_addr),
        .wt_addr      (wt_addr),
        .rd_en        (rd_en),
        .act_data     (act_data),
        .wt_data      (wt_data),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .layer_out    (layer_out),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err)
    );

    // Memory contents and per-cycle expectations (index = cycle after the start edge).
    logic [15:0] act_mem [1024];
    logic [95:0] wt_mem  [1024];
    bit          stl     [MAXC];
    bit          e_rd    [MAXC];
    bit          e_fetch [MAXC];
    bit          e_men   [MAXC];
    bit          e_clr   [MAXC];
    bit          e_rv    [MAXC];
    bit          e_busy  [MAXC];
    logic [9:0]  e_act   [MAXC];
    logic [9:0]  e_wt    [MAXC];
    logic [15:0] e_a     [MAXC];
    logic [95:0] e_b     [MAXC];

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  last_layer = 2'b00;

    function automatic logic [95:0] rand96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic clear_stall();
        for (int i = 0; i < MAXC; i++) stl[i] = 1'b0;
    endtask

    task automatic rand_stall(input int pct);
        for (int i = 0; i < MAXC; i++) stl[i] = ($urandom_range(0, 99) < pct);
    endtask

    // One pass: model the expected trace, drive start, then step and compare every cycle
    // through the first IDLE cycle. rep_c re-pulses start at that cycle; rep_done pulses it in DONE.
    task automatic run_pass(input logic [1:0] layer, input logic [9:0] flen, input logic [9:0] base,
                            input int rep_c, input bit rep_done);
        int         n;
        int         k;
        int         c;
        int         last;
        logic       prev_rd;
        logic [9:0] prev_aa;
        logic [9:0] prev_wa;

        n = (layer == 2'b00) ? 25 : (layer == 2'b01) ? 150 : int'(flen);
        for (int i = 0; i < MAXC; i++) begin
            e_rd[i] = 0; e_fetch[i] = 0; e_men[i] = 0; e_clr[i] = 0; e_rv[i] = 0; e_busy[i] = 0;
            e_act[i] = '0; e_wt[i] = '0; e_a[i] = '0; e_b[i] = '0;
        end
        k = 0;
        c = 1;
        while (k < n) begin
            e_fetch[c] = 1;
            e_busy[c]  = 1;
            e_wt[c]    = 10'(k);
            e_act[c]   = 10'((int'(base) + k) % 1024);
            if (!stl[c]) begin
                e_rd[c]    = 1;
                e_men[c+1] = 1;
                e_clr[c+1] = (k == 0);
                e_a[c+1]   = act_mem[e_act[c]];
                e_b[c+1]   = wt_mem[k];
                k++;
            end
            c++;
        end
        e_busy[c]   = 1;
        e_busy[c+1] = 1;
        e_rv[c+1]   = 1;
        last        = c + 2;

        @(negedge clk);
        start     = 1'b1;
        MAC_layer = layer;
        fc_len    = flen;
        act_base  = base;
        stall     = 1'($urandom);
        act_data  = 16'($urandom);
        wt_data   = rand96();
        @(posedge clk);
        #1;
        start     = 1'b0;
        MAC_layer = 2'($urandom);
        fc_len    = 10'($urandom);
        act_base  = 10'($urandom);
        prev_rd   = 1'b0;
        prev_aa   = '0;
        prev_wa   = '0;
        for (c = 1; c <= last; c++) begin
            stall = stl[c];
            start = (c == rep_c) || (rep_done && e_rv[c]);
            if (prev_rd) begin
                act_data = act_mem[prev_aa];
                wt_data  = wt_mem[prev_wa];
            end else begin
                act_data = 16'($urandom);
                wt_data  = rand96();
            end
            @(negedge clk);
            checks++;
            if (rd_en !== e_rd[c]) begin
                failures++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", c, rd_en, e_rd[c]);
            end
            if (e_fetch[c]) begin
                checks++;
                if (act_addr !== e_act[c]) begin
                    failures++; $display("FAIL act_addr cyc=%0d got=%0d exp=%0d", c, act_addr, e_act[c]);
                end
                checks++;
                if (wt_addr !== e_wt[c]) begin
                    failures++; $display("FAIL wt_addr cyc=%0d got=%0d exp=%0d", c, wt_addr, e_wt[c]);
                end
            end
            checks++;
            if (mac_en !== e_men[c]) begin
                failures++; $display("FAIL mac_en cyc=%0d got=%b exp=%b", c, mac_en, e_men[c]);
            end
            checks++;
            if (mac_clr !== e_clr[c]) begin
                failures++; $display("FAIL mac_clr cyc=%0d got=%b exp=%b", c, mac_clr, e_clr[c]);
            end
            checks++;
            if (mac_a !== e_a[c]) begin
                failures++; $display("FAIL mac_a cyc=%0d got=%h exp=%h", c, mac_a, e_a[c]);
            end
            checks++;
            if (mac_b !== e_b[c]) begin
                failures++; $display("FAIL mac_b cyc=%0d got=%h exp=%h", c, mac_b, e_b[c]);
            end
            checks++;
            if (result_valid !== e_rv[c]) begin
                failures++; $display("FAIL result_valid cyc=%0d got=%b exp=%b", c, result_valid, e_rv[c]);
            end
            checks++;
            if (busy !== e_busy[c]) begin
                failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy, e_busy[c]);
            end
            checks++;
            if (err !== 1'b0) begin
                failures++; $display("FAIL err_in_pass cyc=%0d got=%b exp=0", c, err);
            end
            checks++;
            if (layer_out !== layer) begin
                failures++; $display("FAIL layer_out cyc=%0d got=%b exp=%b", c, layer_out, layer);
            end
            prev_rd = rd_en;
            prev_aa = act_addr;
            prev_wa = wt_addr;
            @(posedge clk);
            #1;
        end
        start      = 1'b0;
        last_layer = layer;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b1;
        MAC_layer = 2'b01;
        fc_len    = 10'($urandom);
        act_base  = 10'($urandom);
        stall     = 1'b0;
        act_data  = 16'($urandom);
        wt_data   = rand96();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, rd_en, mac_en, mac_clr, result_valid, err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {busy, rd_en, mac_en, mac_clr, result_valid, err});
        end
        checks++;
        if ({act_addr, wt_addr, layer_out} !== 22'd0) begin
            failures++; $display("FAIL reset_addr_layer got=%h exp=0", {act_addr, wt_addr, layer_out});
        end
        checks++;
        if ({mac_a, mac_b} !== 112'd0) begin
            failures++; $display("FAIL reset_operands got=%h exp=0", {mac_a, mac_b});
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_conv1();
        clear_stall();
        run_pass(2'b00, 10'd0, 10'd100, -1, 1'b0);
    endtask

    task automatic test_conv2_wrap();
        clear_stall();
        run_pass(2'b01, 10'd0, 10'd1000, -1, 1'b0);
    endtask

    task automatic test_fc_stall();
        clear_stall();
        stl[2] = 1'b1;
        stl[3] = 1'b1;
        run_pass(2'b10, 10'd3, 10'($urandom), -1, 1'b0);
    endtask

    task automatic test_err();
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start     = 1'b1;
            MAC_layer = (t == 0) ? 2'b11 : 2'b10;
            fc_len    = 10'd0;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if ({err, busy} !== 2'b10) begin
                failures++; $display("FAIL err_pulse case=%0d got=%b exp=10", t, {err, busy});
            end
            checks++;
            if (layer_out !== last_layer) begin
                failures++; $display("FAIL err_layer_hold case=%0d got=%b exp=%b", t, layer_out, last_layer);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if ({err, busy} !== 2'b00) begin
                failures++; $display("FAIL err_one_cycle case=%0d got=%b exp=00", t, {err, busy});
            end
        end
    endtask

    task automatic test_restart_ignored();
        clear_stall();
        run_pass(2'b00, 10'd0, 10'($urandom), 5, 1'b1);
    endtask

    task automatic test_reset_mid();
        clear_stall();
        @(negedge clk);
        start     = 1'b1;
        MAC_layer = 2'b00;
        act_base  = 10'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if ({busy, rd_en} !== 2'b11) begin
            failures++; $display("FAIL mid_pre_reset got=%b exp=11", {busy, rd_en});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, rd_en, mac_en, result_valid, layer_out} !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset_async got=%b exp=000000", {busy, rd_en, mac_en, result_valid, layer_out});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({result_valid, busy} !== 2'b00) begin
                failures++; $display("FAIL mid_no_result i=%0d got=%b exp=00", i, {result_valid, busy});
            end
        end
        last_layer = 2'b00;
        run_pass(2'b00, 10'd0, 10'($urandom), -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] ly;
        for (int p = 0; p < 6; p++) begin
            ly = 2'($urandom_range(0, 2));
            rand_stall(30);
            run_pass(ly, 10'($urandom_range(1, 60)), 10'($urandom), -1, 1'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            act_mem[i] = 16'($urandom);
            wt_mem[i]  = rand96();
        end
        test_reset();
        test_conv1();
        test_conv2_wrap();
        test_fc_stall();
        test_err();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
